// File: rtl/register_file_mp.sv
// Multi-port RV32 integer register file with hard-wired x0, programmable SP reset
// value and pending-write scoreboard. Define RF_BYPASS_EN for write-to-read forwarding.
module register_file_mp #(
  parameter int N_REG_ADDR = 5,
  parameter int N_REG      = 32,
  parameter int N_DATA     = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 1,
  parameter int SP_ADDR    = 2,
  parameter int SP_INIT    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_READ*N_REG_ADDR-1:0] rd_addr,
  output logic [N_READ*N_DATA-1:0]     rd_data,
  output logic [N_READ-1:0]            rd_busy,
  input  logic [N_WRITE-1:0]           wr_en,
  input  logic [N_WRITE*N_REG_ADDR-1:0] wr_addr,
  input  logic [N_WRITE*N_DATA-1:0]    wr_data,
  input  logic                         iss_valid,
  input  logic [N_REG_ADDR-1:0]        iss_rd,
  output logic                         busy_any
);

  logic [N_DATA-1:0] regs   [1:N_REG-1];
  logic [N_DATA-1:0] wr_val [1:N_REG-1];
  logic [N_REG-1:1]  busy;
  logic [N_REG-1:1]  wr_hit;
  logic [N_REG-1:1]  iss_hit;

  // Per-register write decode; later ports overwrite earlier ones so the highest index wins.
  always_comb begin
    for (int r = 1; r < N_REG; r++) begin
      wr_hit[r]  = 1'b0;
      wr_val[r]  = '0;
      iss_hit[r] = !rst && iss_valid && (iss_rd == N_REG_ADDR'(r));
      for (int j = 0; j < N_WRITE; j++) begin
        if (!rst && wr_en[j] && (wr_addr[j*N_REG_ADDR +: N_REG_ADDR] == N_REG_ADDR'(r))) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[j*N_DATA +: N_DATA];
        end
      end
    end
  end

  // Address match loop leaves x0 and out-of-range addresses at zero.
  // While rst is high the outputs already show the reset image.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < N_READ; i++) begin
      for (int r = 1; r < N_REG; r++) begin
        if (rd_addr[i*N_REG_ADDR +: N_REG_ADDR] == N_REG_ADDR'(r)) begin
          if (rst) begin
            rd_data[i*N_DATA +: N_DATA] = (r == SP_ADDR) ? N_DATA'(SP_INIT) : '0;
          end else begin
            rd_data[i*N_DATA +: N_DATA] = regs[r];
`ifdef RF_BYPASS_EN
            if (wr_hit[r]) rd_data[i*N_DATA +: N_DATA] = wr_val[r];
`endif
            rd_busy[i] = busy[r];
          end
        end
      end
    end
  end

  assign busy_any = !rst && (|busy);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < N_REG; r++) begin
        regs[r] <= (r == SP_ADDR) ? N_DATA'(SP_INIT) : '0;
      end
      busy <= '0;
    end else begin
      for (int r = 1; r < N_REG; r++) begin
        if (wr_hit[r]) regs[r] <= wr_val[r];
        // A new issue replaces the producer being retired in the same cycle.
        if (iss_hit[r])     busy[r] <= 1'b1;
        else if (wr_hit[r]) busy[r] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed vector table plus randomized
// traffic compared against an array-based reference model.
module tb_register_file_mp;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              busy_any;

  register_file_mp #(
    .N_REG_ADDR(AW), .N_REG(32), .N_DATA(DW), .N_READ(NR), .N_WRITE(NW),
    .SP_ADDR(2), .SP_INIT(255)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m_reg  [32];
  bit          m_busy [32];

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
    logic        eany;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(logic r, logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic iv, logic [4:0] ird,
                              logic [4:0] ra0, logic [4:0] ra1, logic [31:0] ed0,
                              logic [31:0] ed1, logic eb0, logic eb1, logic eany);
    vec_t v;
    v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ird = ird; v.ra0 = ra0; v.ra1 = ra1; v.ed0 = ed0; v.ed1 = ed1;
    v.eb0 = eb0; v.eb1 = eb1; v.eany = eany;
    return v;
  endfunction

  // Reference model: what a read should see this cycle given the current inputs.
  function automatic logic [31:0] exp_rd(logic [4:0] a);
    logic [31:0] v;
    if (rst) return (a == 5'd2) ? 32'd255 : 32'd0;
    if (a == 5'd0) return 32'd0;
    v = m_reg[a];
    if (BYP) begin
      for (int j = 0; j < NW; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
    end
    return v;
  endfunction

  function automatic logic exp_busy(logic [4:0] a);
    if (rst || a == 5'd0) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    logic any = 1'b0;
    for (int r = 0; r < 32; r++) any |= m_busy[r];
    return any && !rst;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r]  = 32'd0;
        m_busy[r] = 1'b0;
      end
      m_reg[2] = 32'd255;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 5'd0) begin
          m_reg[wr_addr[j*AW +: AW]]  = wr_data[j*DW +: DW];
          m_busy[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst;
    wr_en = v.we;
    wr_addr = {v.wa1, v.wa0};
    wr_data = {v.wd1, v.wd0};
    iss_valid = v.iv;
    iss_rd = v.ird;
    rd_addr = {v.ra1, v.ra0};
  endtask

  initial begin
    logic [4:0] ra [NR];
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rd_addr = '0;
    finish_cycle();
    finish_cycle();

    //          rst we     wa0  wd0           wa1  wd1       iv ird  ra0 ra1  ed0                          ed1                        eb0 eb1 eany
    tbl[0]  = mk(1, 2'b00, 0,   0,            0,   0,        0, 0,   1,  2,   0,                           255,                       0,  0,  0);
    tbl[1]  = mk(0, 2'b00, 0,   0,            0,   0,        0, 0,   31, 2,   0,                           255,                       0,  0,  0);
    tbl[2]  = mk(0, 2'b01, 0,   32'hDEADBEEF, 0,   0,        0, 0,   0,  0,   0,                           0,                         0,  0,  0);
    tbl[3]  = mk(0, 2'b11, 5,   32'h11,       5,   32'h22,   0, 0,   5,  0,   BYP ? 32'h22 : 32'h0,        0,                         0,  0,  0);
    tbl[4]  = mk(0, 2'b00, 0,   0,            0,   0,        1, 7,   5,  7,   32'h22,                      0,                         0,  0,  0);
    tbl[5]  = mk(0, 2'b10, 0,   0,            7,   32'h1234, 0, 0,   7,  5,   BYP ? 32'h1234 : 32'h0,      32'h22,                    1,  0,  1);
    tbl[6]  = mk(0, 2'b01, 9,   32'hABCD,     0,   0,        1, 9,   7,  9,   32'h1234,                    BYP ? 32'hABCD : 32'h0,    0,  0,  0);
    tbl[7]  = mk(1, 2'b01, 9,   32'hFFFF,     0,   0,        1, 3,   9,  2,   0,                           255,                       0,  0,  0);
    tbl[8]  = mk(0, 2'b01, 3,   32'h55,       0,   0,        0, 0,   9,  3,   0,                           BYP ? 32'h55 : 32'h0,      0,  0,  0);
    tbl[9]  = mk(0, 2'b00, 0,   0,            0,   0,        1, 0,   3,  9,   32'h55,                      0,                         0,  0,  0);
    tbl[10] = mk(0, 2'b00, 0,   0,            0,   0,        0, 0,   3,  0,   32'h55,                      0,                         0,  0,  0);

    for (int k = 0; k < 11; k++) begin
      drive(tbl[k]);
      @(negedge clk);
      check($sformatf("vec%0d rd_data0", k), rd_data[0 +: DW], tbl[k].ed0);
      check($sformatf("vec%0d rd_data1", k), rd_data[DW +: DW], tbl[k].ed1);
      check($sformatf("vec%0d rd_busy0", k), 32'(rd_busy[0]), 32'(tbl[k].eb0));
      check($sformatf("vec%0d rd_busy1", k), 32'(rd_busy[1]), 32'(tbl[k].eb1));
      check($sformatf("vec%0d busy_any", k), 32'(busy_any), 32'(tbl[k].eany));
      finish_cycle();
    end

    // Post-sequence spot checks after the mid-sequence reset and x3 write.
    drive(mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 9, 7, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("post_rst x9", rd_data[0 +: DW], 32'h0);
    check("post_rst x7", rd_data[DW +: DW], 32'h0);
    finish_cycle();

    // Randomized traffic, mostly on a few low registers to force conflicts and hazards.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int j = 0; j < NW; j++) begin
        wr_en[j] = ($urandom_range(0, 2) != 0);
        wr_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                          : 5'($urandom_range(0, 7));
        wr_data[j*DW +: DW] = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_rd = 5'($urandom_range(0, 9));
      for (int i = 0; i < NR; i++) begin
        ra[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
        rd_addr[i*AW +: AW] = ra[i];
      end
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        check($sformatf("rand c%0d rd_data%0d x%0d", c, i, ra[i]), rd_data[i*DW +: DW], exp_rd(ra[i]));
        check($sformatf("rand c%0d rd_busy%0d x%0d", c, i, ra[i]), 32'(rd_busy[i]), 32'(exp_busy(ra[i])));
      end
      check($sformatf("rand c%0d busy_any", c), 32'(busy_any), 32'(exp_any()));
      finish_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
